// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON permutation engine: state layout,
// round constants, FSM encoding and linear-layer rotation amounts.
package ascon_pack;

  localparam int MAX_ROUNDS = 12;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;

  localparam logic [7:0] ROUND_CONST [0:11] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  typedef enum logic [1:0] {
    PERM_IDLE = 2'd0,
    PERM_RUN  = 2'd1,
    PERM_DONE = 2'd2
  } type_perm_fsm;

  // Pl rotation pairs, indexed by word x0..x4.
  localparam int ROT_A [0:4] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [0:4] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    rotr64 = (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_ps.sv
// ASCON substitution layer: the 5-bit S-box applied bitsliced across all 64 columns.
module ascon_ps
  import ascon_pack::*;
(
  input  type_state s_i,
  output type_state s_o
);

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] b0, b1, b2, b3, b4;

  assign a0 = s_i.x0 ^ s_i.x4;
  assign a1 = s_i.x1;
  assign a2 = s_i.x2 ^ s_i.x1;
  assign a3 = s_i.x3;
  assign a4 = s_i.x4 ^ s_i.x3;

  assign t0 = ~a0 & a1;
  assign t1 = ~a1 & a2;
  assign t2 = ~a2 & a3;
  assign t3 = ~a3 & a4;
  assign t4 = ~a4 & a0;

  assign b0 = a0 ^ t1;
  assign b1 = a1 ^ t2;
  assign b2 = a2 ^ t3;
  assign b3 = a3 ^ t4;
  assign b4 = a4 ^ t0;

  assign s_o.x0 = b0 ^ b4;
  assign s_o.x1 = b1 ^ b0;
  assign s_o.x2 = ~b2;
  assign s_o.x3 = b3 ^ b2;
  assign s_o.x4 = b4;

endmodule

// File: rtl/ascon_round.sv
// One full ASCON round, purely combinational: constant addition, S-box layer,
// then linear diffusion.
module ascon_round
  import ascon_pack::*;
(
  input  type_state   state_i,
  input  logic [7:0]  rc_i,
  output type_state   state_o
);

  type_state pc_out;
  type_state ps_out;

  always_comb begin
    pc_out    = state_i;
    pc_out.x2 = state_i.x2 ^ {56'd0, rc_i};
  end

  ascon_ps u_ps (
    .s_i (pc_out),
    .s_o (ps_out)
  );

  assign state_o.x0 = ps_out.x0 ^ rotr64(ps_out.x0, ROT_A[0]) ^ rotr64(ps_out.x0, ROT_B[0]);
  assign state_o.x1 = ps_out.x1 ^ rotr64(ps_out.x1, ROT_A[1]) ^ rotr64(ps_out.x1, ROT_B[1]);
  assign state_o.x2 = ps_out.x2 ^ rotr64(ps_out.x2, ROT_A[2]) ^ rotr64(ps_out.x2, ROT_B[2]);
  assign state_o.x3 = ps_out.x3 ^ rotr64(ps_out.x3, ROT_A[3]) ^ rotr64(ps_out.x3, ROT_B[3]);
  assign state_o.x4 = ps_out.x4 ^ rotr64(ps_out.x4, ROT_A[4]) ^ rotr64(ps_out.x4, ROT_B[4]);

endmodule

// File: rtl/ascon_perm_engine.sv
// Iterative ASCON permutation: one round per clock on a registered 320-bit
// state, running the last N round constants for N = 1..12.
module ascon_perm_engine
  import ascon_pack::*;
#(
  parameter int MAX_ROUNDS = 12
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] rounds_i,
  input  type_state  state_i,
  output logic       busy_o,
  output logic       done_o,
  output type_state  state_o
);

  // Handshake: start_i is accepted on any edge where the FSM is IDLE or DONE;
  // it is ignored during RUN. done_o is a one-cycle pulse, and state_o holds
  // the result from that cycle until the next accepted start.

  localparam logic [3:0] TOTAL    = 4'(MAX_ROUNDS);
  localparam logic [3:0] LAST_IDX = 4'(MAX_ROUNDS - 1);

  type_perm_fsm fsm, fsm_next;
  type_state    state_reg, state_next;
  type_state    round_in, round_out;
  logic [3:0]   cnt, cnt_next;
  logic [3:0]   base_reg, base_next;
  logic [3:0]   start_rounds, start_base;
  logic [3:0]   rc_idx;
  logic [7:0]   rc;

  assign start_rounds = (rounds_i == 4'd0 || rounds_i > TOTAL) ? TOTAL : rounds_i;
  assign start_base   = TOTAL - start_rounds;
  assign rc           = ROUND_CONST[rc_idx];

  ascon_round u_round (
    .state_i (round_in),
    .rc_i    (rc),
    .state_o (round_out)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm       <= PERM_IDLE;
      state_reg <= '0;
      cnt       <= 4'd0;
      base_reg  <= 4'd0;
    end else begin
      fsm       <= fsm_next;
      state_reg <= state_next;
      cnt       <= cnt_next;
      base_reg  <= base_next;
    end
  end

  always_comb begin
    fsm_next   = fsm;
    state_next = state_reg;
    cnt_next   = cnt;
    base_next  = base_reg;
    round_in   = state_reg;
    rc_idx     = base_reg + cnt;
    case (fsm)
      PERM_IDLE, PERM_DONE: begin
        if (start_i) begin
          round_in   = state_i;
          rc_idx     = start_base;
          state_next = round_out;
          cnt_next   = 4'd1;
          base_next  = start_base;
          fsm_next   = (start_base == LAST_IDX) ? PERM_DONE : PERM_RUN;
        end else begin
          fsm_next = PERM_IDLE;
        end
      end
      PERM_RUN: begin
        state_next = round_out;
        cnt_next   = cnt + 4'd1;
        // This edge applies the last constant, so the result is complete.
        if (base_reg + cnt == LAST_IDX) fsm_next = PERM_DONE;
      end
      default: fsm_next = PERM_IDLE;
    endcase
  end

  assign busy_o  = (fsm == PERM_RUN);
  assign done_o  = (fsm == PERM_DONE);
  assign state_o = state_reg;

endmodule

// File: doc/ascon_perm_engine.md
Name: ascon_perm_engine

Overview:
Iterative ASCON permutation core. It applies one full round per clock cycle to a registered 320-bit state. Each round is constant addition (Pc), then the existing substitution layer Ps, then linear diffusion (Pl). Pc sits directly upstream of Ps and Pl directly downstream of it. A start/done handshake serves the mode controller for both p^a (12 rounds) and p^b (6 rounds).

Parameters:
MAX_ROUNDS, 12, total round-constant count; supported value is 12 only.

Ports:
clock_i  input  1  system clock
reset_i  input  1  synchronous, active-high reset
start_i  input  1  one-cycle request; samples state_i and rounds_i
rounds_i  input  4  number of rounds to run, 1..12
state_i  input  type_state (5x64)  permutation input state
busy_o  output  1  high while rounds are executing
done_o  output  1  one-cycle pulse; state_o holds the result
state_o  output  type_state (5x64)  state register contents

Behaviour:
- Clock and reset: single clock clock_i. reset_i is synchronous and active-high. On reset: FSM=IDLE, state register=0, round counter=0, busy_o=0, done_o=0.
- Rounds: effective rounds N = rounds_i if 1..12, else 12. The first constant index is base = 12-N. Round k (k=0..N-1) uses constant c[base+k].
- Round constants: c[0..11] = f0,e1,d2,c3,b4,a5,96,87,78,69,5a,4b. The constant is XORed into the low byte of word x2 (zero-extended to 64 bits).
- Round datapath (combinational from the round input):
  - Pc on the round input, then Ps (instantiated unchanged), then Pl.
  - Pl: xi ^= rotr(xi,a) ^ rotr(xi,b), with (a,b) = x0:(19,28), x1:(61,39), x2:(1,6), x3:(10,17), x4:(7,41).
- FSM states IDLE, RUN, DONE:
  - IDLE: start_i=1 -> state_reg <= round(state_i, c[base]); cnt <= 1. Go to DONE if N=1, else RUN.
  - RUN: state_reg <= round(state_reg, c[base+cnt]); cnt++. When cnt reaches N-1 on this edge, go to DONE. busy_o=1.
  - DONE: done_o=1 for exactly one cycle. start_i here behaves exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- Latency: done_o goes high N cycles after the start edge; that is 12 for p^a and 6 for p^b.
- state_o = state_reg at all times. The result is held stable in IDLE until the next accepted start.
- start_i during RUN is ignored; there is no queuing, and state and counter are unaffected.
- busy_o = (FSM==RUN). It is 0 in IDLE and DONE.
- reset_i mid-operation aborts: next cycle is IDLE with state_o=0 and no done_o pulse.
- The base index is latched at start. rounds_i changes during RUN have no effect.

Decomposition:
- ascon_pack holds:
  - type_state
  - round-constant array ROUND_CONST[0:11]
  - FSM enum type_perm_fsm
  - rotation amounts
- Sub-modules:
  - Ps is reused as the substitution layer, unchanged.
  - A new combinational sub-module, ascon_round, wraps Pc + Ps + Pl.
  - The engine holds only the FSM, counter and state register.

Test Plan:
1. Reset behaviour: assert reset_i 2 cycles with random state_i and start_i=1 -> state_o=0, busy_o=0, done_o=0 throughout and one cycle after release.
2. Single round, all-zero state_i, rounds_i=1 -> done_o one cycle after the start edge, with state_o.x0 = 0x000964B00000004B and state_o.x4 = 0. All words must match the golden C model.
3. p^a, rounds_i=12, all-zero state_i -> busy_o high for cycles 1..11, done_o at cycle 12. state_o must match the golden-model p^12 of zero, and stays held for 10 further idle cycles.
4. p^b, rounds_i=6, random state_i -> done_o at cycle 6. Result equals golden p^6, which uses constants 96..4b.
5. Handshake corners:
   - start_i pulsed in RUN at cycle 3 -> ignored; result and latency unchanged.
   - start_i held in DONE -> second operation begins immediately; done_o pulses again N cycles later.
   - rounds_i=0 or 13 -> behaves as 12.
6. Reset mid-operation: reset_i at RUN cycle 5 of p^a -> next cycle IDLE, state_o=0, no done_o. A fresh start afterwards completes correctly.
